instr_fetch_buffer: RTL
=======================

# instr_fetch_buffer

Fetch-side consumer of the program counter: owns the fetch PC, issues in-order word reads to instruction memory with a valid/ready request channel, and buffers returned instructions in a small FIFO that feeds decode through a valid/ready output. Taken branches and jumps enter as a redirect, which flushes the buffer and discards in-flight responses. Sits between the PC logic and the decode stage.

## Interface
- DEPTH, 4, FIFO entries and maximum in-flight requests; power of two, ≥2
- RESET_PC, 32'h0, fetch PC loaded on reset
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- redirect_valid  in  1  load new fetch PC, flush
- redirect_pc  in  32  new fetch target
- imem_req_valid  out  1  read request
- imem_req_addr  out  32  word address (byte address, bits[1:0]=0)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  read data returned, in request order, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- out_valid  out  1  instruction available to decode
- out_instr  out  32  instruction at FIFO head
- out_pc  out  32  address of out_instr
- out_ready  in  1  decode consumes head
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Registers: fetch_pc, FIFO (instr+pc per entry), head/tail pointers, count, outstanding (clog2(DEPTH)+1 bits), drop_cnt, state.
- Credit rule: imem_req_valid = (state==FETCH) && (count + outstanding < DEPTH). Independent of redirect_valid and imem_req_ready.
- req_fire = imem_req_valid && imem_req_ready: outstanding+1, fetch_pc += 4 (wraps modulo 2^32).
- FETCH, rsp_valid without redirect: push {rsp_data, pc of oldest outstanding request} into FIFO, outstanding−1. Credit rule guarantees no overflow.
- pop = out_valid && out_ready, where out_valid = (count≠0).
- Redirect (priority over all same-cycle events): FIFO cleared, same-cycle pop ignored; fetch_pc ← {redirect_pc[31:2],2'b00}; drop_cnt ← outstanding + req_fire − rsp_valid (a same-cycle response belongs to the old stream and is discarded). If the result is 0, stay FETCH; else go FLUSH.
- FLUSH: imem_req_valid=0; each rsp_valid decrements drop_cnt and outstanding and is discarded; when the decrement reaches 0, FETCH next cycle. A redirect in FLUSH updates fetch_pc only.
- Response with outstanding==0 is a protocol error; ignored.

## Timing
- Reset (async): fetch_pc=RESET_PC, count=outstanding=drop_cnt=0, state=FETCH, misalign_err=0; while reset is high, imem_req_valid=0 and out_valid=0. First request (addr RESET_PC) is asserted the first cycle after reset deasserts.
- Response→out_valid: 1 cycle (FIFO registered); out_instr/out_pc are stable while out_valid && !out_ready.
- Redirect in cycle N: out_valid=0 in N+1; first new-stream request in N+1 if drop_cnt=0, else the cycle after the last discarded response.
- Back-to-back: with zero-wait memory and out_ready=1, one instruction per cycle sustained.
- Full: count+outstanding=DEPTH → imem_req_valid=0; a simultaneous pop frees credit for the next cycle, not the same cycle.

## Configuration
- IFB_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]≠0 sets misalign_err (sticky until reset); PC is still force-aligned.
- Not defined: misalign_err tied 0; low bits silently dropped.

## Structure
- Shared package: word width, PC increment constant (4), alignment mask, RESET_PC default, state enum {FETCH, FLUSH}.
- One sub-module: ifb_fifo (DEPTH-entry, 64-bit entry, synchronous clear, count output); the control FSM stays in the top.
- A second small pc-tag FIFO holding request addresses is implemented inside ifb_fifo instances (reuse), not a new module.

## Test plan
- Reset release, imem_req_ready=1, 1-cycle memory, out_ready=1 → requests 0,4,8,…; out_pc 0,4,8 with matching data, one per cycle.
- out_ready=0, DEPTH=4 → exactly 4 requests issued, then imem_req_valid=0; after out_ready=1, order preserved, no loss.
- Redirect to 0x100 with 2 requests outstanding → both responses dropped, out_valid=0 until first response from 0x100; out_pc=0x100.
- Redirect in the same cycle as rsp_valid and req_fire → that response is discarded; drop_cnt = outstanding+1−1; no stale instruction reaches decode.
- Two redirects during FLUSH (0x200 then 0x300) → fetch resumes at 0x300 only.
- Redirect to 0x102 → with IFB_MISALIGN_CHECK_EN misalign_err=1 and fetch at 0x100; without, misalign_err=0, fetch at 0x100; assert reset mid-FLUSH → all state cleared, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_buffer_pkg.sv
// ============================================================================
// instr_fetch_buffer_pkg : shared widths, PC constants and fetch FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package instr_fetch_buffer_pkg;
  localparam int          WORD_W           = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } state_e;
endpackage

`default_nettype wire

// File: rtl/instr_fetch_buffer_if.sv
// ============================================================================
// instr_fetch_buffer_if : redirect, imem request/response and decode channels
// Rev 1.0
// ============================================================================
`default_nettype none

interface instr_fetch_buffer_if;
  import instr_fetch_buffer_pkg::*;

  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_pc;
  logic              imem_req_valid;
  logic [WORD_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [WORD_W-1:0] imem_rsp_data;
  logic              out_valid;
  logic [WORD_W-1:0] out_instr;
  logic [WORD_W-1:0] out_pc;
  logic              out_ready;
  logic              misalign_err;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
           misalign_err
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
           misalign_err
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_buffer_fifo.sv
// ============================================================================
// ifb_fifo : DEPTH-entry register FIFO with synchronous clear and count output
// Rev 1.0
// ============================================================================
`default_nettype none

module ifb_fifo
  import instr_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2 * WORD_W
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     clear,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic [WIDTH-1:0]         din,
  output logic      [WIDTH-1:0]         dout,
  output logic      [$clog2(DEPTH):0]   count
);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok  = pop && (count_q != '0);
    push_ok = push && (count_q != FULL_CNT);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + 1'b1;
      if (pop_ok)  head_d = head_q + 1'b1;
      count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read that matters.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[tail_q] <= din;
  end

  assign dout  = mem_q[head_q];
  assign count = count_q;
endmodule

`default_nettype wire

// File: rtl/instr_fetch_buffer.sv
// ============================================================================
// instr_fetch_buffer : fetch PC owner, credit-limited imem reads, decode FIFO
// Optional macro IFB_MISALIGN_CHECK_EN enables the sticky misalign_err flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_buffer
  import instr_fetch_buffer_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input wire logic             clk,
  input wire logic             reset,
  instr_fetch_buffer_if.master bus
);
  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW+1:0] CREDIT = (AW+2)'(DEPTH);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [AW:0]         drop_cnt_q, drop_cnt_d;
  logic [AW:0]         fifo_count, outstanding, outstanding_next;
  logic [2*WORD_W-1:0] fifo_dout;
  logic [WORD_W-1:0]   tag_pc;
  logic                req_fire, rsp_take, push, pop;

  assign bus.imem_req_valid = !reset && (state_q == FETCH) &&
                              (({1'b0, fifo_count} + {1'b0, outstanding}) < CREDIT);
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  // Responses with nothing outstanding are stray and ignored everywhere.
  assign rsp_take           = bus.imem_rsp_valid && (outstanding != '0);
  assign outstanding_next   = outstanding + {{AW{1'b0}}, req_fire}
                                          - {{AW{1'b0}}, rsp_take};
  assign push               = rsp_take && (state_q == FETCH) && !bus.redirect_valid;
  assign pop                = bus.out_valid && bus.out_ready;

  // The tag FIFO's occupancy is the outstanding-request count.
  ifb_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .push  (req_fire),
    .pop   (rsp_take),
    .din   (fetch_pc_q),
    .dout  (tag_pc),
    .count (outstanding)
  );

  ifb_fifo #(.DEPTH(DEPTH), .WIDTH(2*WORD_W)) u_data_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (bus.redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   ({bus.imem_rsp_data, tag_pc}),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign bus.out_valid = (fifo_count != '0);
  assign bus.out_instr = fifo_dout[2*WORD_W-1:WORD_W];
  assign bus.out_pc    = fifo_dout[WORD_W-1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + PC_INC;
    if ((state_q == FLUSH) && rsp_take) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
      if (drop_cnt_q == (AW+1)'(1)) state_d = FETCH;
    end
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ALIGN_MASK;
      // A same-cycle response belongs to the old stream, hence outstanding_next.
      if (state_q == FETCH) begin
        drop_cnt_d = outstanding_next;
        state_d    = (outstanding_next == '0) ? FETCH : FLUSH;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef IFB_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q |
                 (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign bus.misalign_err = misalign_q;
`else
  assign bus.misalign_err = 1'b0;
`endif
endmodule

`default_nettype wire
